// File: rtl/pg_add_sequencer.sv
// Multi-cycle adder: steps a 2-bit propagate/generate slice across WIDTH bits, LSB first.
// Optional whole-word group P/G outputs are enabled with `define PGSEQ_GROUP_PG_EN.
module pg_add_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
`ifdef PGSEQ_GROUP_PG_EN
  ,
  output logic             grp_p,
  output logic             grp_g
`endif
);

  localparam int unsigned N  = WIDTH / 2;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_step;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [1:0]       w_a2;
  logic [1:0]       w_b2;
  logic [1:0]       w_g;
  logic [1:0]       w_p;
  logic             w_c1;
  logic             w_c2;
  logic [1:0]       w_s;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Current slice: bits [2k+1:2k] with k = r_cnt
  assign w_a2 = r_a[{r_cnt, 1'b0} +: 2];
  assign w_b2 = r_b[{r_cnt, 1'b0} +: 2];
  assign w_g  = w_a2 & w_b2;
  assign w_p  = w_a2 ^ w_b2;
  assign w_c1 = w_g[0] | (w_p[0] & r_c);
  assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_c);
  assign w_s  = {w_p[1] ^ w_c1, w_p[0] ^ r_c};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_c   <= cin;
      r_cnt <= '0;
    end else if (w_step) begin
      r_sum[{r_cnt, 1'b0} +: 2] <= w_s;
      r_c <= w_c2;
      if (w_last) begin
        r_cout <= w_c2;
        r_ovf  <= w_c1 ^ w_c2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

`ifdef PGSEQ_GROUP_PG_EN
  logic r_grp_p;
  logic r_grp_g;
  logic w_sp;
  logic w_sg;

  assign w_sp = w_p[1] & w_p[0];
  assign w_sg = w_g[1] | (w_p[1] & w_g[0]);

  // Slices arrive LSB first, so each new slice sits above the accumulated group
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grp_p <= 1'b0;
      r_grp_g <= 1'b0;
    end else if (w_accept) begin
      r_grp_p <= 1'b1;
      r_grp_g <= 1'b0;
    end else if (w_step) begin
      r_grp_g <= w_sg | (w_sp & r_grp_g);
      r_grp_p <= r_grp_p & w_sp;
    end
  end

  assign grp_p = r_grp_p;
  assign grp_g = r_grp_g;
`endif

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: doc/pg_add_sequencer.md
# pg_add_sequencer

Multi-cycle adder controller that steps a 2-bit propagate/generate slice across a WIDTH-bit operand pair, two bits per clock, rippling the carry between slices through a registered carry. Sits between a requester (start/done handshake) and the 2-bit PG datapath. Lets wide additions reuse one small PG slice instead of a full-width carry-lookahead tree.

## Interface
- WIDTH, 16, operand width in bits; even, ≥ 2; N = WIDTH/2 slice steps
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  result, held until next accepted start
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow (carry into MSB xor carry out)
- grp_p, grp_g  output  1 each  whole-word propagate/generate; present only with PGSEQ_GROUP_PG_EN

## Operation
- States: IDLE, RUN, DONE. Slice counter cnt, width ceil(log2 N), range 0..N-1.
- IDLE: start=1 at edge → latch a, b, cin into op registers and carry register c; cnt←0; → RUN. start=0 → stay.
- RUN, each cycle, slice k=cnt on bits [2k+1:2k]: g_i = a_i & b_i, p_i = a_i ^ b_i; c1 = g0 | p0&c; c2 = g1 | p1&g0 | p1&p0&c; sum[2k] = p0^c; sum[2k+1] = p1^c1; c←c2.
- RUN, cnt=N-1: additionally cout←c2, ovf←c1^c2; → DONE. Otherwise cnt←cnt+1.
- DONE: done=1 for exactly one cycle; → IDLE unconditionally.
- start in RUN or DONE: ignored, not queued; operand registers unaffected.
- a, b, cin may change freely after the accepting edge.
- sum/cout/ovf written only by RUN; stable in IDLE and DONE.
- Arithmetic modulo 2^WIDTH; carry out only via cout.
- WIDTH=2: single RUN cycle, cnt constant 0.

## Timing
- Reset (rst_n=0 at edge): state IDLE, cnt=0, c=0, busy=0, done=0, sum=0, cout=0, ovf=0, grp_p=0, grp_g=0. Applies mid-RUN/DONE: operation discarded, no done pulse.
- start accepted at edge E: busy=1 from E; RUN during edges E+1..E+N; done=1 in cycle following edge E+N; busy=0 and IDLE after edge E+N+1.
- Latency start-accept → done: N cycles (8 for WIDTH=16). Throughput: one add per N+2 cycles.
- sum, cout, ovf final and valid when done=1; remain valid through IDLE.
- start=1 held continuously: re-accepted at first IDLE edge, i.e. edge E+N+2.
- rst_n and start both asserted at same edge: reset wins.

## Configuration
- PGSEQ_GROUP_PG_EN defined: grp_p and grp_g ports exist. At accept, grp_p←1, grp_g←0. Each RUN slice: slice P = p1&p0, slice G = g1|p1&g0; grp_g←G | P&grp_g; grp_p←grp_p&P. Final values valid with done, held like sum. grp_p=1 means the word propagates cin to cout; grp_g=1 means cout=1 independent of cin.
- Undefined: ports absent, no group logic; all other behaviour identical.

## Test plan
- WIDTH=16, a=0x00FF, b=0x0001, cin=0, start one cycle → done exactly 8 cycles after accept, sum=0x0100, cout=0, ovf=0, busy high 9 cycles.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- a=0x5555, b=0xAAAA, cin=1 → sum=0x0000, cout=1; with PGSEQ_GROUP_PG_EN grp_p=1, grp_g=0; repeat cin=0 → sum=0xFFFF, cout=0.
- Accept a=0x1234, b=0x1111; pulse start with a=0xFFFF at cycles 3 and 9 (RUN/DONE) → ignored, sum=0x2345, single done pulse.
- rst_n=0 one cycle at RUN cycle 4 → next cycle all outputs 0, IDLE, no done; new start a=0x0001, b=0x0001 → sum=0x0002 after 8 cycles.
- start held high 30 cycles, a=0x0003, b=0x0005 → accepts every 10 cycles, done pulses 10 cycles apart, sum=0x0008 each time.
